baud_gen_frac: RTL
==================

Name: baud_gen_frac

Overview:
Programmable fractional baud-tick generator for the UART. It produces a one-cycle rxclk_en pulse at OVERSAMPLE × baud and a phase-locked txclk_en pulse at baud. The divisor is an integer part plus a fractional part, so rates such as 115200 at 50 MHz carry no cumulative error. The divisor can be rewritten at run time from the control logic.

Parameters:
DIV_WIDTH, 16, width of the integer divisor (clock cycles per rx tick)
FRAC_BITS, 8, width of the fractional divisor; the fraction unit is 1/2^FRAC_BITS cycle
OVERSAMPLE, 16, number of rx ticks per tx tick (must be ≥2)
DEFAULT_DIV_INT, 27, integer divisor loaded at reset (50 MHz / (115200×16) = 27.126)
DEFAULT_DIV_FRAC, 32, fractional divisor loaded at reset (0.126×256 ≈ 32)

Ports:
clk_50m  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  generator enable
div_wr  input  1  one-cycle strobe that writes a new divisor
div_int_in  input  DIV_WIDTH  new integer divisor
div_frac_in  input  FRAC_BITS  new fractional divisor
div_int_q  output  DIV_WIDTH  active integer divisor (readback)
div_frac_q  output  FRAC_BITS  active fractional divisor (readback)
div_pending  output  1  a staged divisor is waiting to be applied
rxclk_en  output  1  oversample tick, one-cycle pulse
txclk_en  output  1  bit tick, one-cycle pulse

Behaviour:
- Interface: one clock, clk_50m. rst is synchronous and active-high; it is sampled only on the rising edge of clk_50m.
- Reset state:
  - cnt=0, os_cnt=0, frac_acc=0.
  - div_int_q=DEFAULT_DIV_INT, div_frac_q=DEFAULT_DIV_FRAC.
  - rxclk_en=0, txclk_en=0, div_pending=0.
- All outputs are registered.
- Each enabled cycle (en=1, rst=0):
  - If cnt==0:
    - rxclk_en<=1.
    - {carry, frac_acc} <= frac_acc + div_frac_q, evaluated FRAC_BITS+1 bits wide.
    - cnt <= div_int_q - 1 + carry.
    - txclk_en<=1 if os_cnt==0, else 0.
    - os_cnt <= (os_cnt==OVERSAMPLE-1) ? 0 : os_cnt+1.
  - Otherwise: cnt<=cnt-1, rxclk_en<=0, txclk_en<=0.
- Timing consequences:
  - The first rxclk_en and txclk_en assert together, in the cycle after the first enabled edge following reset.
  - Spacing between rx ticks is div_int_q cycles, or div_int_q+1 cycles when the accumulator carries.
  - Over 2^FRAC_BITS ticks, exactly div_frac_q of them take the +1 cycle.
  - txclk_en is always coincident with an rxclk_en, once every OVERSAMPLE rx ticks.
- en=0:
  - cnt, os_cnt and frac_acc clear to 0; rxclk_en and txclk_en are 0.
  - Raising en again restarts exactly as after reset, with the divisor retained.
- Divisor clamp: a written div_int_in below 2 is stored as 2. div_frac_in is stored unmodified.
- Immediate divisor update (default, macro absent):
  - A div_wr strobe updates div_int_q/div_frac_q on the next edge.
  - On that same edge cnt, os_cnt and frac_acc clear, so the next tick fires immediately (phase restart).
  - If div_wr coincides with a tick cycle, the write wins: the tick pulse is still emitted, but the counters clear.
  - A write while en=0 is accepted.
  - A write during rst is ignored.
- rst has priority over en and div_wr at all times, including mid-period.

Optional Feature:
Macro BAUD_DIV_SHADOW_EN.
- Defined:
  - div_wr captures the value into shadow registers and sets div_pending=1; the counters are not disturbed.
  - The shadow is applied at the next tx boundary: the cycle where cnt==0 and os_cnt==0.
  - The reload in that cycle already uses the new div_int/div_frac.
  - On that cycle div_pending clears, frac_acc clears, and the txclk_en pulse is still emitted.
  - Repeated writes while pending: the last one wins.
  - A write in the same cycle as the boundary is staged for the next boundary.
  - With en=0, a write applies immediately.
- Undefined: div_pending is tied to 0 and the immediate-update behaviour above applies.

Test Plan:
- Reset, then en=1 with default divisor -> first rxclk_en and txclk_en in the cycle after the first enabled edge; rx spacing 27 or 28 cycles; 256 consecutive rx periods total 27×256+32 = 6944 cycles; txclk_en every 16th rxclk_en.
- Write div_int_in=4, div_frac_in=0 mid-period (macro absent) -> restart tick on the following cycle, then rxclk_en exactly every 4 cycles and txclk_en every 64 cycles.
- Write div_int_in=0 -> div_int_q reads 2; rxclk_en pulses every 2 cycles.
- Write div_int_in=5, div_frac_in=128 (FRAC_BITS=8) -> rx periods alternate 5,6,5,6…; 512 ticks total exactly 2816 cycles.
- Drop en for 10 cycles mid-period, then raise it -> both pulses are 0 while disabled; the first tick comes in the cycle after the first enabled edge, with rx and tx coincident.
- With BAUD_DIV_SHADOW_EN: write 10/0 after rx tick 3 of a 16-tick frame -> div_pending=1; the old spacing holds until the next txclk_en, which uses the new divisor for the following period; div_pending clears on that cycle.

Source files
------------

// File: rtl/baud_gen_frac.sv
// baud_gen_frac - programmable fractional baud-tick generator.
//
// Emits a one-cycle rxclk_en pulse at OVERSAMPLE x baud and a phase-locked
// txclk_en pulse at baud (every OVERSAMPLE-th rx tick, coincident with it).
// The rx period is div_int_q cycles, stretched by one cycle whenever the
// fractional accumulator carries, so over 2^FRAC_BITS ticks exactly
// div_frac_q of them are one cycle longer.
//
// Optional build macro: BAUD_DIV_SHADOW_EN
//   undefined : a divisor write takes effect on the next edge and restarts
//               the tick phase; div_pending is tied low.
//   defined   : a divisor write is staged in shadow registers and applied at
//               the next tx boundary (or immediately while en=0).
//
// Ports:
//   clk_50m      in   system clock
//   rst          in   synchronous active-high reset
//   en           in   generator enable
//   div_wr       in   one-cycle strobe writing a new divisor
//   div_int_in   in   [DIV_WIDTH-1:0] new integer divisor (values <2 stored as 2)
//   div_frac_in  in   [FRAC_BITS-1:0] new fractional divisor
//   div_int_q    out  active integer divisor
//   div_frac_q   out  active fractional divisor
//   div_pending  out  staged divisor waiting for a tx boundary
//   rxclk_en     out  oversample tick
//   txclk_en     out  bit tick
module baud_gen_frac #(
    parameter int DIV_WIDTH        = 16,
    parameter int FRAC_BITS        = 8,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 27,
    parameter int DEFAULT_DIV_FRAC = 32
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_wr,
    input  logic [DIV_WIDTH-1:0] div_int_in,
    input  logic [FRAC_BITS-1:0] div_frac_in,
    output logic [DIV_WIDTH-1:0] div_int_q,
    output logic [FRAC_BITS-1:0] div_frac_q,
    output logic                 div_pending,
    output logic                 rxclk_en,
    output logic                 txclk_en
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    logic [DIV_WIDTH-1:0] cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [FRAC_BITS-1:0] frac_acc;

    logic [DIV_WIDTH-1:0] wr_int;
    logic [FRAC_BITS:0]   acc_sum;
    logic [DIV_WIDTH-1:0] cnt_reload;
    logic                 tick;
    logic                 os_last;

    // Divisors below 2 would make cnt_reload underflow; store them as 2.
    assign wr_int  = (div_int_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_int_in;

    // Carry out of the accumulator lengthens the coming period by one cycle.
    assign acc_sum    = {1'b0, frac_acc} + {1'b0, div_frac_q};
    assign cnt_reload = div_int_q - DIV_WIDTH'(1) + DIV_WIDTH'(acc_sum[FRAC_BITS]);
    assign tick       = (cnt == '0);
    assign os_last    = (os_cnt == OS_W'(OVERSAMPLE - 1));

`ifdef BAUD_DIV_SHADOW_EN
    logic [DIV_WIDTH-1:0] sh_int;
    logic [FRAC_BITS-1:0] sh_frac;
`else
    assign div_pending = 1'b0;
`endif

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt        <= '0;
            os_cnt     <= '0;
            frac_acc   <= '0;
            div_int_q  <= DIV_WIDTH'(DEFAULT_DIV_INT);
            div_frac_q <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            rxclk_en   <= 1'b0;
            txclk_en   <= 1'b0;
`ifdef BAUD_DIV_SHADOW_EN
            sh_int      <= DIV_WIDTH'(DEFAULT_DIV_INT);
            sh_frac     <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            div_pending <= 1'b0;
`endif
        end else begin
            if (!en) begin
                // Disabled: park at the restart point so re-enabling ticks at once.
                cnt      <= '0;
                os_cnt   <= '0;
                frac_acc <= '0;
                rxclk_en <= 1'b0;
                txclk_en <= 1'b0;
            end else if (tick) begin
                rxclk_en <= 1'b1;
                txclk_en <= (os_cnt == '0);
                os_cnt   <= os_last ? '0 : os_cnt + 1'b1;
`ifdef BAUD_DIV_SHADOW_EN
                if (div_pending && os_cnt == '0) begin
                    // tx boundary: swap in the staged divisor and reload with it.
                    div_int_q   <= sh_int;
                    div_frac_q  <= sh_frac;
                    div_pending <= 1'b0;
                    frac_acc    <= '0;
                    cnt         <= sh_int - 1'b1;
                end else begin
                    frac_acc <= acc_sum[FRAC_BITS-1:0];
                    cnt      <= cnt_reload;
                end
`else
                frac_acc <= acc_sum[FRAC_BITS-1:0];
                cnt      <= cnt_reload;
`endif
            end else begin
                cnt      <= cnt - 1'b1;
                rxclk_en <= 1'b0;
                txclk_en <= 1'b0;
            end

            // Placed after the tick logic so a write overrides the counter update
            // of the same cycle (the pulse itself is still emitted).
            if (div_wr) begin
`ifdef BAUD_DIV_SHADOW_EN
                if (!en) begin
                    div_int_q   <= wr_int;
                    div_frac_q  <= div_frac_in;
                    div_pending <= 1'b0;
                end else begin
                    sh_int      <= wr_int;
                    sh_frac     <= div_frac_in;
                    div_pending <= 1'b1;
                end
`else
                div_int_q  <= wr_int;
                div_frac_q <= div_frac_in;
                cnt        <= '0;
                os_cnt     <= '0;
                frac_acc   <= '0;
`endif
            end
        end
    end

endmodule
